mmio_hub: RTL and testbench
===========================

# mmio_hub

Parametrised memory-mapped I/O hub for the single-cycle core. It decodes a word-aligned register window at `BASE` and forwards every other address to data RAM. It buffers keyboard bytes in a FIFO with sticky overflow, and provides a microsecond timer with compare interrupt, an LED register and an interrupt-enable control register. It replaces the fixed-address keyboard/clock/LED decode with a generalised, interrupt-capable block.

## Interface
- `BASE`, 32'hfbadc000, register window base; window is `BASE`..`BASE+0x17`.
- `KBD_DEPTH`, 8, keyboard FIFO depth; power of two, ≥2.
- `CLK_PER_US`, 50, clk cycles per microsecond tick; ≥1.
- `LED_WIDTH`, 32, LED register width; 1..32.

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `load`  in  1  CPU load this cycle.
- `store`  in  1  CPU store this cycle.
- `access`  in  3  funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- `addr`  in  32  byte address.
- `data_in`  in  32  store data.
- `kbd_valid`  in  1  one-cycle strobe from the PS/2 receiver.
- `kbd_data`  in  8  scan byte; qualified by `kbd_valid`.
- `ram_data_out`  in  32  RAM read data.
- `ram_load`  out  1  `load` forwarded when the address is outside the window.
- `ram_store`  out  1  `store` forwarded when the address is outside the window.
- `data_out`  out  32  load result, combinational.
- `led_data`  out  `LED_WIDTH`  LED register.
- `kbd_overflow`  out  1  sticky FIFO overflow flag.
- `irq`  out  1  level interrupt to the core.

## Operation
- Hit: `addr[31:5]==BASE[31:5]` and `addr[4:2]`≤5. All other addresses, including window offsets 0x18–0x1F, go to RAM. `ram_load`/`ram_store` equal `load`/`store` and `data_out=ram_data_out`.
- Reads: a hit returns the full 32-bit register value for any `access`; the core performs byte extraction and extension. `addr[1:0]` is ignored.
- Writes: register writes take effect only when `access==3'b010`. Stores of other widths to the window are dropped and forwarded nowhere.
- Register map (offset, name, behaviour):
  - 0x00 KBD_DATA (R): `{24'b0, head}`. The load pops one entry if the FIFO is non-empty; an empty FIFO reads 0 and nothing pops.
  - 0x04 KBD_STATUS (R/W): read returns `{16'b0, count[7:0], 6'b0, overflow, nonempty}`. Any sw clears `overflow`.
  - 0x08 US_COUNT (R/W): 32-bit microsecond counter. An sw loads `data_in` and zeroes the prescaler.
  - 0x0C TIMER_CMP (R/W): compare value. An sw also clears `timer_pend`.
  - 0x10 LED (R/W): `led_data <= data_in[LED_WIDTH-1:0]`. Read returns the value zero-extended.
  - 0x14 CTRL (R/W, bits[1:0]): bit0 timer IRQ enable, bit1 keyboard IRQ enable. Reads return zeros above bit 1.
- FIFO:
  - Push: on `kbd_valid` when not full.
  - Full: a push while full drops the byte and sets `overflow`.
  - Push and pop in the same cycle: both occur, count is unchanged. When full, this is not an overflow.
  - Pointers: wrap modulo `KBD_DEPTH`. `count` is $clog2(KBD_DEPTH)+1 bits wide.
- Timer:
  - Prescaler counts 0..CLK_PER_US-1. On wrap, `us_count` increments modulo 2^32.
  - When `us_count` increments to a value equal to `cmp`, `timer_pend` is set.
  - A same-cycle sw to US_COUNT has priority over the increment: no increment and no compare match that cycle.
  - A sw to TIMER_CMP in the same cycle as a match: the clear wins.
- `irq = (ctrl[0] & timer_pend) | (ctrl[1] & nonempty)`.

## Timing
- Reset values:
  - FIFO empty, pointers 0, `overflow` 0.
  - `us_count` 0, prescaler 0, `cmp` 32'hffffffff, `timer_pend` 0.
  - `led_data` 0, `ctrl` 0, `irq` 0.
- `rst` asserted mid-operation discards FIFO contents immediately.
- `data_out` is combinational from current state and inputs, with zero latency.
- Pops, register writes and flag changes are visible from the cycle after the edge.
- `load` held N cycles on KBD_DATA pops N entries; the core asserts `load` for exactly one cycle per instruction.
- `irq` is registered-state-derived and changes one cycle after the causing edge. It is level-sensitive; software clears it by writing TIMER_CMP or draining the FIFO.

## Test plan
- FIFO order and empty read: reset; push 0x1C, 0x32 on separate cycles; lw KBD_STATUS → 0x00000201. lbu KBD_DATA twice → 0x1C, then 0x32. A third read → 0, status 0x00000000.
- Overflow: push 9 bytes with `KBD_DEPTH`=8. Status → 0x00000803 and `kbd_overflow`=1; the 9th byte is lost. A same-cycle push+pop at full keeps count 8 with no extra overflow. sw 0 to KBD_STATUS → 0x00000801.
- Timer tick: `CLK_PER_US`=4. After 40 cycles US_COUNT reads 10. sw 100 to US_COUNT; 4 cycles later it reads 101.
- Compare IRQ: sw CTRL=1, TIMER_CMP=5, US_COUNT=0. `irq` rises one cycle after the count reaches 5. sw TIMER_CMP=20 → `irq` 0 next cycle.
- LED and width filtering: sw 0xA5A5A5A5 to LED → `led_data`=0xA5A5A5A5. sb 0xFF to LED → unchanged, `ram_store`=0.
- RAM passthrough and reset: load at 0x00001000 → `ram_load`=1, `data_out`=`ram_data_out`. Load at BASE+0x18 → forwarded to RAM. Assert `rst` mid-stream → all outputs return to reset values immediately.

Source files
------------

// File: rtl/mmio_hub.sv
// mmio_hub: memory-mapped I/O hub for the single-cycle core.
//
// Decodes a six-register word window at BASE (offsets 0x00..0x14) and
// forwards every other address, including window offsets 0x18..0x1F, to
// data RAM. It contains a keyboard byte FIFO with a sticky overflow flag, a
// microsecond timer with a compare interrupt, an LED register and an
// interrupt-enable control register.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   load, store     CPU load/store strobes for this cycle
//   access          funct3 of the access (only lw-width stores write registers)
//   addr, data_in   byte address and store data
//   kbd_valid/data  one-cycle scan byte strobe from the PS/2 receiver
//   ram_data_out    RAM read data, returned on window misses
//   ram_load/store  load/store forwarded to RAM on window misses
//   data_out        combinational load result
//   led_data        LED register
//   kbd_overflow    sticky FIFO overflow flag
//   irq             level interrupt to the core
//
// Register map (word offset):
//   0x00 KBD_DATA    read pops the FIFO head (0 when empty)
//   0x04 KBD_STATUS  {count, overflow, nonempty}; any write clears overflow
//   0x08 US_COUNT    microsecond counter; write loads it and zeroes the prescaler
//   0x0C TIMER_CMP   compare value; write clears the pending timer interrupt
//   0x10 LED         LED register
//   0x14 CTRL        bit0 timer irq enable, bit1 keyboard irq enable
module mmio_hub #(
  parameter logic [31:0] BASE       = 32'hfbadc000,
  parameter int          KBD_DEPTH  = 8,
  parameter int          CLK_PER_US = 50,
  parameter int          LED_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 store,
  input  logic [2:0]           access,
  input  logic [31:0]          addr,
  input  logic [31:0]          data_in,
  input  logic                 kbd_valid,
  input  logic [7:0]           kbd_data,
  input  logic [31:0]          ram_data_out,
  output logic                 ram_load,
  output logic                 ram_store,
  output logic [31:0]          data_out,
  output logic [LED_WIDTH-1:0] led_data,
  output logic                 kbd_overflow,
  output logic                 irq
);

  localparam int AW = $clog2(KBD_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_US - 1);
  localparam logic [CW-1:0] FIFO_FULL  = CW'(KBD_DEPTH);

  // Address decode
  logic       hit;
  logic [2:0] idx;
  logic       wr_en;
  logic       wr_stat, wr_us, wr_cmp, wr_led, wr_ctrl;

  assign idx       = addr[4:2];
  assign hit       = (addr[31:5] == BASE[31:5]) && (idx <= 3'd5);
  assign ram_load  = load & ~hit;
  assign ram_store = store & ~hit;

  // Narrow stores into the window are swallowed: not registers, not RAM.
  assign wr_en   = store & hit & (access == 3'b010);
  assign wr_stat = wr_en & (idx == 3'd1);
  assign wr_us   = wr_en & (idx == 3'd2);
  assign wr_cmp  = wr_en & (idx == 3'd3);
  assign wr_led  = wr_en & (idx == 3'd4);
  assign wr_ctrl = wr_en & (idx == 3'd5);

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^addr[1:0];

  // Keyboard FIFO
  logic [7:0]    fifo_mem [KBD_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          nonempty, full, pop, push, ovf_set;
  logic [7:0]    head;

  assign nonempty = (count_q != '0);
  assign full     = (count_q == FIFO_FULL);
  assign head     = fifo_mem[rd_ptr_q];
  assign pop      = load & hit & (idx == 3'd0) & nonempty;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign push     = kbd_valid & (~full | pop);
  assign ovf_set  = kbd_valid & full & ~pop;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    // A new overflow in the same cycle as the clearing write is kept.
    ovf_d    = (ovf_q & ~wr_stat) | ovf_set;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= kbd_data;
  end

  // Microsecond timer
  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   us_q, us_d;
  logic [31:0]   cmp_q, cmp_d;
  logic          pend_q, pend_d;
  logic          match;
  logic [31:0]   us_inc;

  assign us_inc = us_q + 32'd1;

  always_comb begin
    presc_d = presc_q;
    us_d    = us_q;
    match   = 1'b0;
    if (wr_us) begin
      us_d    = data_in;
      presc_d = '0;
    end else if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      us_d    = us_inc;
      match   = (us_inc == cmp_q);
    end else begin
      presc_d = presc_q + 1'b1;
    end
    cmp_d  = wr_cmp ? data_in : cmp_q;
    pend_d = wr_cmp ? 1'b0 : (pend_q | match);
  end

  // LED and control
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [1:0]           ctrl_q, ctrl_d;

  always_comb begin
    led_d  = wr_led  ? data_in[LED_WIDTH-1:0] : led_q;
    ctrl_d = wr_ctrl ? data_in[1:0] : ctrl_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      presc_q  <= '0;
      us_q     <= '0;
      cmp_q    <= 32'hffffffff;
      pend_q   <= 1'b0;
      led_q    <= '0;
      ctrl_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      presc_q  <= presc_d;
      us_q     <= us_d;
      cmp_q    <= cmp_d;
      pend_q   <= pend_d;
      led_q    <= led_d;
      ctrl_q   <= ctrl_d;
    end
  end

  // Read mux
  logic [31:0] led_ext, cnt_ext, reg_rd;

  always_comb begin
    led_ext = '0;
    led_ext[LED_WIDTH-1:0] = led_q;
    cnt_ext = '0;
    cnt_ext[CW-1:0] = count_q;
    case (idx)
      3'd0:    reg_rd = nonempty ? {24'b0, head} : 32'b0;
      3'd1:    reg_rd = {16'b0, cnt_ext[7:0], 6'b0, ovf_q, nonempty};
      3'd2:    reg_rd = us_q;
      3'd3:    reg_rd = cmp_q;
      3'd4:    reg_rd = led_ext;
      3'd5:    reg_rd = {30'b0, ctrl_q};
      default: reg_rd = 32'b0;
    endcase
  end

  assign data_out     = hit ? reg_rd : ram_data_out;
  assign led_data     = led_q;
  assign kbd_overflow = ovf_q;
  assign irq          = (ctrl_q[0] & pend_q) | (ctrl_q[1] & nonempty);

endmodule

// File: tb/tb_mmio_hub.sv
// Self-checking bench for mmio_hub: directed scenarios followed by random
// traffic, all compared against a queue-based behavioural model.
module tb_mmio_hub;

  localparam logic [31:0] BASE  = 32'hfbadc000;
  localparam int          DEPTH = 8;
  localparam int          CPU   = 4;
  localparam int          LW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          load, store;
  logic [2:0]    access;
  logic [31:0]   addr, data_in;
  logic          kbd_valid;
  logic [7:0]    kbd_data;
  logic [31:0]   ram_data_out;
  logic          ram_load, ram_store;
  logic [31:0]   data_out;
  logic [LW-1:0] led_data;
  logic          kbd_overflow;
  logic          irq;

  mmio_hub #(.BASE(BASE), .KBD_DEPTH(DEPTH), .CLK_PER_US(CPU), .LED_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .load(load), .store(store), .access(access),
    .addr(addr), .data_in(data_in), .kbd_valid(kbd_valid), .kbd_data(kbd_data),
    .ram_data_out(ram_data_out), .ram_load(ram_load), .ram_store(ram_store),
    .data_out(data_out), .led_data(led_data), .kbd_overflow(kbd_overflow), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model
  logic [7:0]  mq[$];
  bit          m_ovf;
  logic [31:0] m_us, m_cmp, m_led;
  int          m_presc;
  logic [1:0]  m_ctrl;
  bit          m_pend;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_hit(input logic [31:0] a);
    return (a[31:5] == BASE[31:5]) && (a[4:2] <= 3'd5);
  endfunction

  function automatic logic [31:0] m_read();
    logic [31:0] r;
    if (!m_hit(addr)) return ram_data_out;
    case (addr[4:2])
      3'd0: r = (mq.size() > 0) ? {24'b0, mq[0]} : 32'b0;
      3'd1: r = {16'b0, 8'(mq.size()), 6'b0, m_ovf, mq.size() > 0};
      3'd2: r = m_us;
      3'd3: r = m_cmp;
      3'd4: r = m_led;
      default: r = {30'b0, m_ctrl};
    endcase
    return r;
  endfunction

  function automatic bit m_irq();
    return (m_ctrl[0] && m_pend) || (m_ctrl[1] && mq.size() > 0);
  endfunction

  task automatic m_reset();
    mq.delete();
    m_ovf = 0; m_us = 0; m_presc = 0; m_cmp = 32'hffffffff;
    m_pend = 0; m_led = 0; m_ctrl = 0;
  endtask

  task automatic m_clock();
    bit h    = m_hit(addr);
    int off  = int'(addr[4:2]);
    bit wr   = store && h && (access == 3'b010);
    bit pop  = load && h && (off == 0) && (mq.size() > 0);
    bit full = (mq.size() == DEPTH);
    if (pop) void'(mq.pop_front());
    if (wr && off == 1) m_ovf = 0;
    if (kbd_valid) begin
      if (!full || pop) mq.push_back(kbd_data);
      else m_ovf = 1;
    end
    if (wr && off == 2) begin
      m_us = data_in; m_presc = 0;
    end else if (m_presc == CPU - 1) begin
      m_presc = 0;
      m_us = m_us + 32'd1;
      if (m_us == m_cmp) m_pend = 1;
    end else begin
      m_presc++;
    end
    if (wr && off == 3) begin m_cmp = data_in; m_pend = 0; end
    if (wr && off == 4) m_led = data_in;
    if (wr && off == 5) m_ctrl = data_in[1:0];
  endtask

  task automatic set_idle();
    load = 0; store = 0; access = 3'b010; addr = 32'h0; data_in = 32'h0;
    kbd_valid = 0; kbd_data = 8'h0; ram_data_out = $urandom;
  endtask

  task automatic bus(input bit ld, input bit st, input logic [2:0] acc,
                     input logic [31:0] a, input logic [31:0] d,
                     input bit kv = 0, input logic [7:0] kd = 8'h0);
    load = ld; store = st; access = acc; addr = a; data_in = d;
    kbd_valid = kv; kbd_data = kd;
  endtask

  // Check outputs against the model, clock once, advance the model.
  task automatic step();
    #1;
    chk("data_out", data_out, m_read());
    chk("ram_load", 32'(ram_load), 32'(load && !m_hit(addr)));
    chk("ram_store", 32'(ram_store), 32'(store && !m_hit(addr)));
    chk("led_data", 32'(led_data), m_led);
    chk("kbd_overflow", 32'(kbd_overflow), 32'(m_ovf));
    chk("irq", 32'(irq), 32'(m_irq()));
    @(posedge clk);
    m_clock();
    #2;
    set_idle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic sw(input logic [31:0] off, input logic [31:0] d);
    bus(0, 1, 3'b010, BASE + off, d);
    step();
  endtask

  task automatic rd(input string tag, input logic [31:0] off, input logic [2:0] acc,
                    input logic [31:0] exp);
    bus(1, 0, acc, BASE + off, 32'h0);
    #1 chk(tag, data_out, exp);
    step();
  endtask

  task automatic push(input logic [7:0] b);
    bus(0, 0, 3'b010, 32'h0, 32'h0, 1, b);
    step();
  endtask

  task automatic do_reset();
    set_idle();
    addr = BASE + 32'h0c;
    rst = 1;
    #1;
    chk("rst_cmp", data_out, 32'hffffffff);
    chk("rst_led", 32'(led_data), 32'h0);
    chk("rst_ovf", 32'(kbd_overflow), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    addr = BASE + 32'h04;
    #1 chk("rst_status", data_out, 32'h0);
    m_reset();
    @(posedge clk);
    #2;
    rst = 0;
    set_idle();
  endtask

  initial begin
    logic [31:0] a, d;
    logic [2:0]  acc;
    int          off, op;
    rst = 0;
    set_idle();
    #2;
    do_reset();

    // FIFO order and empty read
    push(8'h1c);
    push(8'h32);
    rd("status_two", 32'h04, 3'b010, 32'h00000201);
    rd("kbd_first", 32'h00, 3'b100, 32'h0000001c);
    rd("kbd_second", 32'h00, 3'b100, 32'h00000032);
    rd("kbd_empty", 32'h00, 3'b010, 32'h0);
    rd("status_empty", 32'h04, 3'b010, 32'h0);

    // Overflow
    do_reset();
    for (int i = 0; i < 9; i++) push(8'(8'h40 + i));
    rd("status_ovf", 32'h04, 3'b010, 32'h00000803);
    chk("ovf_flag", 32'(kbd_overflow), 32'h1);
    sw(32'h04, 32'h0);
    rd("status_cleared", 32'h04, 3'b010, 32'h00000801);
    bus(1, 0, 3'b010, BASE, 32'h0, 1, 8'h99);
    #1 chk("pushpop_head", data_out, 32'h40);
    step();
    rd("status_pushpop", 32'h04, 3'b010, 32'h00000801);
    chk("ovf_after_pushpop", 32'(kbd_overflow), 32'h0);
    for (int i = 0; i < 7; i++) rd("drain", 32'h00, 3'b010, 32'(8'h41 + i));
    rd("drain_last", 32'h00, 3'b010, 32'h99);

    // Timer tick
    do_reset();
    idle(40);
    rd("us_40", 32'h08, 3'b010, 32'd10);
    sw(32'h08, 32'd100);
    idle(4);
    rd("us_101", 32'h08, 3'b010, 32'd101);

    // Compare IRQ
    do_reset();
    sw(32'h14, 32'h1);
    sw(32'h0c, 32'd5);
    sw(32'h08, 32'd0);
    idle(19);
    chk("irq_before", 32'(irq), 32'h0);
    idle(1);
    chk("irq_match", 32'(irq), 32'h1);
    sw(32'h0c, 32'd20);
    chk("irq_cleared", 32'(irq), 32'h0);

    // LED and width filtering
    sw(32'h10, 32'ha5a5a5a5);
    chk("led_set", 32'(led_data), 32'ha5a5a5a5);
    bus(0, 1, 3'b000, BASE + 32'h10, 32'hff);
    #1 chk("sb_ram_store", 32'(ram_store), 32'h0);
    step();
    chk("led_kept", 32'(led_data), 32'ha5a5a5a5);

    // RAM passthrough
    bus(1, 0, 3'b010, 32'h00001000, 32'h0);
    ram_data_out = 32'h12345678;
    #1 chk("ram_ld", 32'(ram_load), 32'h1);
    chk("ram_data", data_out, 32'h12345678);
    step();
    bus(1, 0, 3'b010, BASE + 32'h18, 32'h0);
    ram_data_out = 32'hcafef00d;
    #1 chk("ram_ld_18", 32'(ram_load), 32'h1);
    chk("ram_data_18", data_out, 32'hcafef00d);
    step();

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      op  = $urandom_range(0, 2);
      acc = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 5)) : 3'b010;
      if (acc == 3'b011) acc = 3'b100;
      off = $urandom_range(0, 9);
      if (off > 7) off = 0;
      if ($urandom_range(0, 9) < 8) a = BASE + 32'(off * 4 + $urandom_range(0, 3));
      else a = $urandom;
      d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
      bus(op == 1, op == 2, acc, a, d, $urandom_range(0, 3) == 0, 8'($urandom));
      ram_data_out = $urandom;
      step();
    end

    // Reset mid-stream
    sw(32'h14, 32'h3);
    push(8'h5a);
    sw(32'h10, 32'h0000beef);
    chk("irq_pre_rst", 32'(irq), 32'h1);
    do_reset();
    rd("kbd_after_rst", 32'h00, 3'b010, 32'h0);
    rd("ctrl_after_rst", 32'h14, 3'b010, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
